pc_stack_seq: RTL



---
 rtl/pc_stack_seq_if.sv | 32 +++
 rtl/pc_stack_seq.sv | 112 +++++++++++
 2 files changed

// File: rtl/pc_stack_seq_if.sv
// Bus between the decoder and the program counter / return-address stack.
// The decoder side (master) drives the control pulses and the branch field.
// The PC side (slave) returns the program address and the stack status.
interface pc_stack_seq_if #(
  parameter int P = 6,
  parameter int D = 4
);
  localparam int SW = $clog2(D + 1);

  logic          stall;
  logic          pc_incr;
  logic          pc_rel;
  logic          pc_abs;
  logic          pc_call;
  logic          pc_ret;
  logic [P-1:0]  branch_addr;
  logic [P-1:0]  pcout;
  logic [SW-1:0] sp_level;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  modport master (
    output stall, pc_incr, pc_rel, pc_abs, pc_call, pc_ret, branch_addr,
    input  pcout, sp_level, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  stall, pc_incr, pc_rel, pc_abs, pc_call, pc_ret, branch_addr,
    output pcout, sp_level, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_stack_seq.sv
// Program counter with a hardware return-address stack (strict LIFO).
// It supports increment, signed relative branch, absolute branch, call and return.
// Stack overflow and underflow set a sticky error flag, and only reset clears it.
// Optional build macro PC_STACK_TRAP_EN: a stack fault redirects the PC to TRAP_ADDR.
// Without the macro, a faulting call still jumps to branch_addr,
// and a faulting return falls through to pc+1.
module pc_stack_seq #(
  parameter int           P          = 6,
  parameter int           D          = 4,
  parameter logic [P-1:0] RESET_ADDR = '0,
  parameter logic [P-1:0] TRAP_ADDR  = {P{1'b1}}
) (
  input logic            clk,
  input logic            reset,
  pc_stack_seq_if.slave  bus
);

  localparam int SW = $clog2(D + 1);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam logic [SW-1:0] SP_ONE  = SW'(1);
  localparam logic [SW-1:0] SP_FULL = SW'(D);

`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [P-1:0]  pc_q, pc_d;
  logic [SW-1:0] sp_q, sp_d;
  logic          err_q, err_d;
  logic [P-1:0]  stack_q [D];
  logic [P-1:0]  stack_d [D];

  logic [P-1:0]  pc_inc;
  logic [SW-1:0] sp_dec;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;
  logic          full;
  logic          empty;

  assign pc_inc   = pc_q + P'(1);
  assign sp_dec   = sp_q - SP_ONE;
  // sp_q < D whenever these are used, so the truncation to AW bits is lossless.
  assign push_idx = sp_q[AW-1:0];
  assign pop_idx  = sp_dec[AW-1:0];
  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == '0);

  // Next-state selection. Stall freezes everything.
  // Among the controls, return beats call, call beats absolute, absolute beats relative,
  // and relative beats increment.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (!bus.stall) begin
      if (bus.pc_ret) begin
        if (empty) begin
          err_d = 1'b1;
          pc_d  = TRAP_EN ? TRAP_ADDR : pc_inc;
        end else begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_dec;
        end
      end else if (bus.pc_call) begin
        if (full) begin
          err_d = 1'b1;
          pc_d  = TRAP_EN ? TRAP_ADDR : bus.branch_addr;
        end else begin
          stack_d[push_idx] = pc_inc;
          sp_d              = sp_q + SP_ONE;
          pc_d              = bus.branch_addr;
        end
      end else if (bus.pc_abs) begin
        pc_d = bus.branch_addr;
      end else if (bus.pc_rel) begin
        // The offset and the PC have the same width, so a plain modulo-2^P add
        // already treats branch_addr as a sign-extended two's-complement offset.
        pc_d = pc_q + bus.branch_addr;
      end else if (bus.pc_incr) begin
        pc_d = pc_inc;
      end
    end
  end

  // PC, stack pointer and sticky error register. Reset overrides stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage. The contents are don't-care after reset, so reset does not touch them.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.pcout       = pc_q;
  assign bus.sp_level    = sp_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

endmodule
